// File: rtl/vme_master_pkg.sv
// Shared types and constants for the VME A24/D16 bus master.
package vme_master_pkg;

    // Bus-cycle sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } vme_state_e;

    // Decoded transaction kind.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } vme_op_e;

    // Command word fields.
    localparam int CMD_RD_BIT = 25;
    localparam int CMD_WR_BIT = 24;

    // Result word status flags.
    localparam int STAT_DTACK_TO_BIT = 31;
    localparam int STAT_REL_TO_BIT   = 30;

    // Data returned when the slave never acknowledges.
    localparam logic [15:0] TO_DATA = 16'hDEAD;

    // Read wins over write when both command bits are set.
    function automatic vme_op_e decode_op(input logic rd_bit, input logic wr_bit);
        if (rd_bit) begin
            return OP_READ;
        end else if (wr_bit) begin
            return OP_WRITE;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchronizer for an active-low asynchronous input; resets to the
// deasserted (high) level so a floating DTACK reads as "no acknowledge".
module vme_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vme_master_seq.sv
// VME A24/D16 bus master: takes one command/data pair, runs a full
// AS/DS/DTACK cycle and returns the result with a one-cycle strobe.
// Handshake: a command is taken on a rising edge where start=1 and
// vme_cmd_rd=1; vme_dat_wr is high for exactly one cycle with
// vme_dat_reg_out valid, and vme_dat_reg_out holds until the next strobe.
// Bus outputs are decoded from registered state so an asynchronous reset
// releases every strobe immediately.
module vme_master_seq
    import vme_master_pkg::*;
#(
    parameter logic [5:0] AM_CODE     = 6'h39,
    parameter int         SETUP_CYC   = 2,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [22:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic        vme_write_b,
    output logic        vme_as_b,
    output logic [1:0]  vme_ds_b,
    output logic [15:0] vme_data_out,
    output logic        vme_data_oe,
    input  logic [15:0] vme_data_in,
    input  logic        vme_dtack_b
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC);
    localparam int              SU_W    = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(SETUP_CYC - 1);

    vme_state_e      state_q, state_d;
    vme_op_e         op_q, op_d;
    logic [22:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [31:0]     res_q, res_d;
    logic [31:0]     out_q, out_d;
    logic [SU_W-1:0] su_cnt_q, su_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            dtk;

    // Command bits outside the decoded fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{vme_cmd_reg[31:26], vme_cmd_reg[0], vme_dat_reg_in[31:16]};

    vme_sync2 u_dtack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (vme_dtack_b),
        .q_o   (dtk)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction datapath and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            res_q    <= '0;
            out_q    <= '0;
            su_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            res_q    <= res_d;
            out_q    <= out_d;
            su_cnt_q <= su_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        res_d    = res_q;
        out_d    = out_q;
        su_cnt_d = su_cnt_q;
        // Saturating: a stuck counter still reads as expired, never as fresh.
        to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETUP;
                    op_d     = decode_op(vme_cmd_reg[CMD_RD_BIT], vme_cmd_reg[CMD_WR_BIT]);
                    addr_d   = vme_cmd_reg[23:1];
                    wdata_d  = vme_dat_reg_in[15:0];
                    res_d    = '0;
                    su_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (op_q == OP_NONE) begin
                    // No bus cycle: report an all-zero result.
                    state_d = ST_DONE;
                end else if (su_cnt_q == SU_LAST) begin
                    state_d  = ST_STROBE;
                    to_cnt_d = '0;
                end else begin
                    su_cnt_d = su_cnt_q + 1'b1;
                end
            end
            ST_STROBE: begin
                if (!dtk) begin
                    res_d[15:0] = (op_q == OP_READ) ? vme_data_in : wdata_q;
                    state_d     = ST_RELEASE;
                    to_cnt_d    = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    res_d[15:0]              = TO_DATA;
                    res_d[STAT_DTACK_TO_BIT] = 1'b1;
                    state_d                  = ST_RELEASE;
                    to_cnt_d                 = '0;
                end
            end
            ST_RELEASE: begin
                if (dtk) begin
                    state_d = ST_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    res_d[STAT_REL_TO_BIT] = 1'b1;
                    state_d                = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Publish the result only as the completion strobe begins.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            out_d = res_d;
        end
    end

    // Bus and handshake outputs decoded from registered state.
    always_comb begin
        vme_cmd_rd      = (state_q == ST_IDLE);
        vme_dat_wr      = (state_q == ST_DONE);
        vme_dat_reg_out = out_q;
        vme_addr        = '0;
        vme_am          = '0;
        vme_write_b     = 1'b1;
        vme_as_b        = 1'b1;
        vme_ds_b        = 2'b11;
        vme_data_out    = '0;
        vme_data_oe     = 1'b0;

        if ((op_q != OP_NONE) && (state_q inside {ST_SETUP, ST_STROBE, ST_RELEASE})) begin
            vme_addr    = addr_q;
            vme_am      = AM_CODE;
            vme_write_b = (op_q != OP_WRITE);
        end

        if ((op_q != OP_NONE) && (state_q inside {ST_SETUP, ST_STROBE})) begin
            vme_as_b = 1'b0;
            if (op_q == OP_WRITE) begin
                vme_data_out = wdata_q;
                vme_data_oe  = 1'b1;
            end
        end

        if (state_q == ST_STROBE) begin
            vme_ds_b = 2'b00;
        end
    end

endmodule

// File: tb/tb_vme_master_seq.sv
// Directed bench for vme_master_seq with a behavioural VME slave.
module tb_vme_master_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_write_b;
    logic        vme_as_b;
    logic [1:0]  vme_ds_b;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in;
    logic        vme_dtack_b;

    int checks;
    int failures;

    // Observations from the last transaction.
    int          obs_lat;
    int          obs_pulses;
    int          obs_ds_cycles;
    int          obs_ds_eps;
    logic        obs_as_seen;
    logic        obs_oe_seen;
    logic        obs_done;
    logic [22:0] obs_addr;
    logic [5:0]  obs_am;
    logic        obs_wb;
    logic [15:0] obs_dout;
    logic        obs_oe_ds;
    logic [31:0] obs_out;
    logic        obs_end_as;
    logic [1:0]  obs_end_ds;
    logic        obs_end_oe;
    logic        obs_rdy_after;

    vme_master_seq #(
        .AM_CODE     (6'h39),
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .vme_cmd_reg     (vme_cmd_reg),
        .vme_dat_reg_in  (vme_dat_reg_in),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .vme_addr        (vme_addr),
        .vme_am          (vme_am),
        .vme_write_b     (vme_write_b),
        .vme_as_b        (vme_as_b),
        .vme_ds_b        (vme_ds_b),
        .vme_data_out    (vme_data_out),
        .vme_data_oe     (vme_data_oe),
        .vme_data_in     (vme_data_in),
        .vme_dtack_b     (vme_dtack_b)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction. dly: DS-low observations before DTACK (0 = immediate),
    // -1 = slave never answers, -2 = DTACK left as the caller set it (stuck).
    // hold keeps start high after acceptance.
    task automatic do_txn(input logic [31:0] cmd, input logic [31:0] wdat,
                          input int dly, input logic [15:0] rdat, input logic hold);
        int   n;
        int   ds_seen;
        logic prev_ds_low;
        obs_lat = 0; obs_pulses = 0; obs_ds_cycles = 0; obs_ds_eps = 0;
        obs_as_seen = 1'b0; obs_oe_seen = 1'b0; obs_done = 1'b0;
        obs_addr = '0; obs_am = '0; obs_wb = 1'b1; obs_dout = '0; obs_oe_ds = 1'b0;
        obs_out = '0; obs_end_as = 1'b0; obs_end_ds = 2'b00; obs_end_oe = 1'b1;
        obs_rdy_after = 1'b0;
        ds_seen = 0;
        prev_ds_low = 1'b0;
        start          = 1'b1;
        vme_cmd_reg    = cmd;
        vme_dat_reg_in = wdat;
        @(posedge clk);
        n = 0;
        while (!obs_done && n < 60) begin
            @(negedge clk);
            n++;
            if (!hold && n == 1) start = 1'b0;
            if (vme_as_b == 1'b0) obs_as_seen = 1'b1;
            if (vme_data_oe == 1'b1) obs_oe_seen = 1'b1;
            if (vme_ds_b == 2'b00) begin
                obs_ds_cycles++;
                if (!prev_ds_low) obs_ds_eps++;
                obs_addr  = vme_addr;
                obs_am    = vme_am;
                obs_wb    = vme_write_b;
                obs_dout  = vme_data_out;
                obs_oe_ds = vme_data_oe;
            end
            prev_ds_low = (vme_ds_b == 2'b00);
            if (vme_dat_wr) begin
                obs_pulses++;
                obs_lat    = n;
                obs_out    = vme_dat_reg_out;
                obs_end_as = vme_as_b;
                obs_end_ds = vme_ds_b;
                obs_end_oe = vme_data_oe;
            end else if (obs_pulses > 0) begin
                obs_rdy_after = vme_cmd_rd;
                obs_done      = 1'b1;
            end
            // Slave response for the next half cycle.
            if (dly != -2) begin
                if (vme_ds_b == 2'b00) begin
                    ds_seen++;
                    if (dly >= 0 && ds_seen > dly) begin
                        vme_dtack_b = 1'b0;
                        vme_data_in = rdat;
                    end
                end else begin
                    vme_dtack_b = 1'b1;
                end
            end
        end
        check("txn_completed", obs_done, 1'b1);
    endtask

    initial begin
        int n;
        int pulses;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        vme_cmd_reg    = '0;
        vme_dat_reg_in = '0;
        vme_data_in    = '0;
        vme_dtack_b    = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cmd_rd",   vme_cmd_rd, 1'b1);
        check("rst_dat_wr",   vme_dat_wr, 1'b0);
        check("rst_dat_out",  vme_dat_reg_out, 32'h0);
        check("rst_as_b",     vme_as_b, 1'b1);
        check("rst_ds_b",     vme_ds_b, 2'b11);
        check("rst_write_b",  vme_write_b, 1'b1);
        check("rst_oe",       vme_data_oe, 1'b0);
        check("rst_addr",     vme_addr, 23'h0);
        check("rst_am",       vme_am, 6'h0);
        check("rst_data_out", vme_data_out, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_rd", vme_cmd_rd, 1'b1);

        // Write, DTACK 3 cycles after DS.
        do_txn(32'h01A83000, 32'h0000BEEF, 3, 16'h0000, 1'b0);
        check("wr_addr",    obs_addr, 23'h541800);
        check("wr_am",      obs_am, 6'h39);
        check("wr_write_b", obs_wb, 1'b0);
        check("wr_dout",    obs_dout, 16'hBEEF);
        check("wr_oe",      obs_oe_ds, 1'b1);
        check("wr_pulses",  obs_pulses, 1);
        check("wr_result",  obs_out, 32'h0000BEEF);
        check("wr_latency", obs_lat, 12);
        check("wr_ds_cyc",  obs_ds_cycles, 6);
        check("wr_ready",   obs_rdy_after, 1'b1);

        // Read, DTACK one cycle after DS.
        do_txn(32'h02A83004, 32'h00000000, 1, 16'h1234, 1'b0);
        check("rd_addr",    obs_addr, 23'h541802);
        check("rd_write_b", obs_wb, 1'b1);
        check("rd_oe_any",  obs_oe_seen, 1'b0);
        check("rd_result",  obs_out, 32'h00001234);
        check("rd_latency", obs_lat, 10);
        check("rd_pulses",  obs_pulses, 1);

        // Slave never answers: DTACK timeout after 16 DS cycles.
        do_txn(32'h02000100, 32'h00000000, -1, 16'h0000, 1'b0);
        check("to_ds_cyc",  obs_ds_cycles, 16);
        check("to_result",  obs_out, 32'h8000DEAD);
        check("to_pulses",  obs_pulses, 1);
        check("to_latency", obs_lat, 20);
        check("to_end_as",  obs_end_as, 1'b1);
        check("to_end_ds",  obs_end_ds, 2'b11);
        check("to_end_oe",  obs_end_oe, 1'b0);

        // Neither read nor write: no bus activity, result cleared.
        do_txn(32'h00A80010, 32'h00001111, 0, 16'h0000, 1'b0);
        check("nop_as",      obs_as_seen, 1'b0);
        check("nop_ds",      obs_ds_cycles, 0);
        check("nop_latency", obs_lat, 2);
        check("nop_result",  obs_out, 32'h0);
        check("nop_pulses",  obs_pulses, 1);

        // Stuck DTACK: taken as acknowledge, then release timeout.
        @(negedge clk);
        vme_dtack_b = 1'b0;
        repeat (3) @(negedge clk);
        do_txn(32'h01000020, 32'h00005A5A, -2, 16'h0000, 1'b0);
        check("stk_result",  obs_out, 32'h40005A5A);
        check("stk_ds_cyc",  obs_ds_cycles, 1);
        check("stk_latency", obs_lat, 20);
        vme_dtack_b = 1'b1;
        repeat (3) @(negedge clk);

        // start held high: back-to-back, one bus cycle each, latency 9.
        do_txn(32'h02000200, 32'h00000000, 0, 16'h0F0F, 1'b1);
        check("b2b0_latency", obs_lat, 9);
        check("b2b0_eps",     obs_ds_eps, 1);
        check("b2b0_pulses",  obs_pulses, 1);
        check("b2b0_result",  obs_out, 32'h00000F0F);
        do_txn(32'h01000202, 32'h0000C3C3, 0, 16'h0000, 1'b1);
        start = 1'b0;
        check("b2b1_latency", obs_lat, 9);
        check("b2b1_eps",     obs_ds_eps, 1);
        check("b2b1_pulses",  obs_pulses, 1);
        check("b2b1_result",  obs_out, 32'h0000C3C3);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (vme_as_b == 1'b0 || vme_dat_wr) pulses++;
        end
        check("b2b_quiet",   pulses, 0);
        check("b2b_cmd_rd",  vme_cmd_rd, 1'b1);
        check("b2b_hold_out", vme_dat_reg_out, 32'h0000C3C3);

        // Reset during STROBE: strobes release before the next edge.
        @(negedge clk);
        start       = 1'b1;
        vme_cmd_reg = 32'h02000300;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vme_ds_b !== 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_strobe", vme_ds_b, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        check("mid_as_b",   vme_as_b, 1'b1);
        check("mid_ds_b",   vme_ds_b, 2'b11);
        check("mid_cmd_rd", vme_cmd_rd, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (vme_dat_wr) pulses++;
        end
        check("mid_no_dat_wr", pulses, 0);
        check("mid_ready",     vme_cmd_rd, 1'b1);
        check("mid_as_idle",   vme_as_b, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vme_master_seq.md
Name: vme_master_seq

Overview:
- Synthesizable VME A24/D16 bus master. Sits directly downstream of the simulation command-file driver.
- Accepts one command word plus a write-data word per transaction and runs a full AS/DS/DTACK bus cycle.
- Returns read data, or echoes write data, with a one-cycle completion strobe.
- Signals readiness for the next command on vme_cmd_rd.

Parameters:
- AM_CODE, 6'h39, address modifier driven on vme_am (A24 non-privileged data).
- SETUP_CYC, 2, clocks address/data/WRITE are held stable before DS asserts (min 1).
- TIMEOUT_CYC, 1024, clocks to wait for each DTACK edge before aborting (min 4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command valid; sampled only while vme_cmd_rd=1
- vme_cmd_reg  in  32  [25]=read, [24]=write, [23:0]=byte address
- vme_dat_reg_in  in  32  [15:0]=write data
- vme_cmd_rd  out  1  ready to accept a command
- vme_dat_wr  out  1  one-cycle completion strobe
- vme_dat_reg_out  out  32  [31]=DTACK timeout, [30]=release timeout, [15:0]=data
- vme_addr  out  23  address bits [23:1]
- vme_am  out  6  address modifier
- vme_write_b  out  1  low = write cycle
- vme_as_b  out  1  address strobe, active low
- vme_ds_b  out  2  data strobes, active low; both driven (D16)
- vme_data_out  out  16  write data to bus
- vme_data_oe  out  1  bus data driver enable
- vme_data_in  in  16  read data from bus
- vme_dtack_b  in  1  asynchronous DTACK, active low

Behaviour:
- Reset (async, rst_n=0): state IDLE; vme_cmd_rd=1; vme_dat_wr=0; vme_dat_reg_out=0; vme_as_b=1; vme_ds_b=2'b11; vme_write_b=1; vme_data_oe=0; vme_addr=0; vme_am=0; vme_data_out=0.
- Reset mid-cycle: strobes release immediately (asynchronously); the transaction is discarded and no vme_dat_wr is produced.
- vme_dtack_b passes through a 2-flop synchronizer. All DTACK decisions use the synchronized value (dtk).
- Accept: rising edge with start=1 and vme_cmd_rd=1. Latch cmd and data; vme_cmd_rd=0 from the next cycle.
- start while vme_cmd_rd=0 is ignored; no queueing.
- Command decode: [25]=1 gives a read (priority over [24]). Else [24]=1 gives a write.
- Neither bit set: no bus cycle. Go straight to DONE with vme_dat_reg_out=0.
- States:
  - IDLE: vme_cmd_rd=1. On accept go to SETUP.
  - SETUP: drive vme_addr=cmd[23:1], vme_am=AM_CODE, vme_write_b=~write. On a write, drive vme_data_out and set vme_data_oe=1. Assert vme_as_b=0 on the first SETUP cycle. Hold SETUP_CYC cycles, then go to STROBE.
  - STROBE: vme_ds_b=2'b00; timeout counter runs.
    - dtk=0: on a read, capture vme_data_in into data[15:0]; on a write, data[15:0]=latched write data. Go to RELEASE.
    - Counter reaches TIMEOUT_CYC-1 first: data[15:0]=16'hDEAD, bit31=1, go to RELEASE.
  - RELEASE: vme_ds_b=2'b11, vme_as_b=1, vme_data_oe=0; counter restarts.
    - dtk=1: go to DONE.
    - Timeout: set bit30 and go to DONE.
  - DONE: vme_dat_wr=1 for exactly one cycle with vme_dat_reg_out valid; next state IDLE.
- vme_dat_reg_out holds its value until the next DONE.
- Timeout counter: clog2(TIMEOUT_CYC) bits. Cleared on entry to STROBE and to RELEASE; saturates, never wraps.
- DTACK already low on STROBE entry (stuck slave): accepted as an acknowledge. The release timeout then flags it.
- Accept-to-vme_dat_wr latency with immediate DTACK: SETUP_CYC + 2 (sync) + 1 (STROBE) + 3 (release sync) + 1 cycles. This is 9 at the defaults. A bench must be able to hit that exact value.

Decomposition:
- Package vme_master_pkg:
  - state encoding (IDLE, SETUP, STROBE, RELEASE, DONE)
  - CMD_RD_BIT=25, CMD_WR_BIT=24
  - TO_DATA=16'hDEAD
  - status bit positions 31 and 30
- One sub-module: vme_sync2, a 2-flop synchronizer with async active-low reset; reset value 1 (deasserted).

Test Plan:
- Write: cmd 0x01A83000, data 0x0000BEEF, slave asserts DTACK 3 cycles after DS → vme_addr=0x541800, vme_write_b=0, vme_data_out=0xBEEF, vme_data_oe=1, one vme_dat_wr pulse, vme_dat_reg_out=0x0000BEEF, vme_cmd_rd returns 1.
- Read: cmd 0x02A83004, slave returns 0x1234 with DTACK → vme_write_b=1, vme_data_oe=0 throughout, vme_dat_reg_out=0x00001234.
- DTACK never asserted, TIMEOUT_CYC=16 → DS held 16 cycles, vme_dat_reg_out=0x8000DEAD, vme_dat_wr pulses once, bus strobes all released.
- cmd 0x00A80010 (neither bit set) → no AS/DS activity, vme_dat_wr 2 cycles after accept, vme_dat_reg_out=0.
- rst_n pulled low during STROBE → vme_as_b=1, vme_ds_b=11 immediately (before next edge), no vme_dat_wr, vme_cmd_rd=1 after release.
- start held high across a whole transaction → exactly one bus cycle per vme_cmd_rd high window; immediate-DTACK latency equals 9 cycles.
